// File: rtl/arbiter_4ch_priority.sv
//------------------------------------------------------------------------------
// arbiter_4ch_priority
//
// Purpose:
//   Four-requester arbiter with a registered one-hot grant. Arbitration happens
//   only from IDLE, so a new owner is chosen one clock after requests arrive.
//   An owner keeps the grant for as long as it holds its request. If another
//   requester is waiting, the owner is forced off after MAX_HOLD grant cycles,
//   and preempt pulses for one cycle. There is always at least one all-zero
//   grant cycle between two tenures.
//
// Configuration:
//   ARB_ROUND_ROBIN_EN - when defined, the most recent owner gets the lowest
//                        priority on the next arbitration. When undefined,
//                        fixed priority applies and req[3] always wins.
//
// Parameters:
//   MAX_HOLD   - grant cycles before a contended owner is preempted (2..255)
//
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset
//   req[3:0]   - level-held request vector
//   gnt[3:0]   - registered one-hot grant, zero when there is no owner
//   gnt_id[1:0]- registered index of the owner, zero when gnt_valid is low
//   gnt_valid  - registered, equal to |gnt
//   preempt    - registered one-cycle pulse on a timeout-forced release
//------------------------------------------------------------------------------
module arbiter_4ch_priority #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic       preempt_q, preempt_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;

  logic [1:0] win_id;
  logic       win_any;
  logic       others_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] last_id_q, last_id_d;
  logic [1:0] cand;

  // The search order is last_id-1, last_id-2, last_id-3, then last_id.
  // Walking from the lowest-priority slot up lets the last hit win.
  always_comb begin
    win_id = 2'd0;
    cand   = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      cand = last_id_q - 2'(k);
      if (req[cand]) begin
        win_id = cand;
      end
    end
  end
`else
  // The highest asserted index wins. The upward walk lets req[3] overwrite
  // any lower bit.
  always_comb begin
    win_id = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (req[i]) begin
        win_id = 2'(i);
      end
    end
  end
`endif

  assign win_any    = |req;
  assign others_req = |(req & ~gnt_q);

  // Next-state and registered-output logic. Every path out of BUSY goes
  // through IDLE, which gives the mandatory empty grant cycle. A release
  // caused by the owner dropping its request is checked first, so it takes
  // precedence over a timeout in the same cycle.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    preempt_d   = 1'b0;
    hold_cnt_d  = hold_cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_id_d   = last_id_q;
`endif

    case (state_q)
      IDLE: begin
        gnt_d       = 4'b0000;
        gnt_id_d    = 2'd0;
        gnt_valid_d = 1'b0;
        hold_cnt_d  = 8'd0;
        if (win_any) begin
          state_d     = BUSY;
          gnt_d       = 4'b0001 << win_id;
          gnt_id_d    = win_id;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = 8'd1;
`ifdef ARB_ROUND_ROBIN_EN
          last_id_d   = win_id;
`endif
        end
      end

      BUSY: begin
        if (!req[gnt_id_q]) begin
          state_d     = IDLE;
          gnt_d       = 4'b0000;
          gnt_id_d    = 2'd0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = 8'd0;
        end else if ((hold_cnt_q == MAX_HOLD_C) && others_req) begin
          state_d     = IDLE;
          gnt_d       = 4'b0000;
          gnt_id_d    = 2'd0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = 8'd0;
          preempt_d   = 1'b1;
        end else if (hold_cnt_q != MAX_HOLD_C) begin
          hold_cnt_d  = hold_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset clears the grant right away, without
  // waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= 4'b0000;
      gnt_id_q    <= 2'd0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
      hold_cnt_q  <= 8'd0;
`ifdef ARB_ROUND_ROBIN_EN
      last_id_q   <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      preempt_q   <= preempt_d;
      hold_cnt_q  <= hold_cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_id_q   <= last_id_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_arbiter_4ch_priority.sv
//------------------------------------------------------------------------------
// tb_arbiter_4ch_priority
//
// Purpose:
//   Directed bench for the four-channel arbiter. It runs two instances side by
//   side on the same inputs:
//     - dut  uses the default MAX_HOLD of 8
//     - dut4 uses MAX_HOLD of 4, so timeouts are short
//   Every expected value below was worked out by hand from the arbiter's
//   behaviour.
//------------------------------------------------------------------------------
module tb_arbiter_4ch_priority;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;

  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       preempt;

  logic [3:0] gnt4;
  logic [1:0] gnt_id4;
  logic       gnt_valid4;
  logic       preempt4;

  int checkCount;
  int errorCount;

  logic [1:0] rrExpect [5];

  arbiter_4ch_priority dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  arbiter_4ch_priority #(.MAX_HOLD(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt4),
    .gnt_id    (gnt_id4),
    .gnt_valid (gnt_valid4),
    .preempt   (preempt4)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compares one observed value against its expected value, counts the
  // comparison, and reports it when the two differ.
  task automatic checkOutput(input string tag, input logic [7:0] actual,
                             input logic [7:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, actual, expected);
    end
  endtask

  // Drives the request vector, then advances to 1 time unit after the next
  // rising edge, where the outputs are stable and can be sampled.
  task automatic applyStimulus(input logic [3:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  // Holds reset across two edges with no requests, then releases it between
  // edges. The next applyStimulus call is therefore the first arbitration.
  task automatic doReset();
    rst_n = 1'b0;
    req   = 4'b0000;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Main directed sequence.
  initial begin
    checkCount = 0;
    errorCount = 0;
`ifdef ARB_ROUND_ROBIN_EN
    rrExpect = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
`else
    rrExpect = '{2'd3, 2'd2, 2'd3, 2'd2, 2'd3};
`endif
    rst_n = 1'b0;
    req   = 4'b0000;
    #12;

    // All outputs are zero while reset is held.
    checkOutput("rst_gnt",     8'(gnt),       8'h0);
    checkOutput("rst_gnt_id",  8'(gnt_id),    8'h0);
    checkOutput("rst_valid",   8'(gnt_valid), 8'h0);
    checkOutput("rst_preempt", 8'(preempt),   8'h0);
    doReset();

    // With no requests the arbiter stays idle.
    applyStimulus(4'b0000);
    checkOutput("idle_gnt",   8'(gnt),       8'h0);
    checkOutput("idle_valid", 8'(gnt_valid), 8'h0);

    // Fixed priority: req 0101 grants channel 2 one edge later.
    applyStimulus(4'b0101);
    checkOutput("fp_gnt",    8'(gnt),       8'h04);
    checkOutput("fp_gnt_id", 8'(gnt_id),    8'h02);
    checkOutput("fp_valid",  8'(gnt_valid), 8'h01);

    // Other requests, including a higher-index one, leave the owner alone.
    applyStimulus(4'b0101);
    checkOutput("fp_hold1", 8'(gnt), 8'h04);
    applyStimulus(4'b1101);
    checkOutput("fp_hold2", 8'(gnt), 8'h04);

    // Release gap: the owner drops, one empty cycle follows, then channel 0
    // gets the grant.
    applyStimulus(4'b0001);
    checkOutput("gap_gnt",    8'(gnt),       8'h0);
    checkOutput("gap_valid",  8'(gnt_valid), 8'h0);
    checkOutput("gap_gnt_id", 8'(gnt_id),    8'h0);
    applyStimulus(4'b0001);
    checkOutput("gap_next_gnt", 8'(gnt),    8'h01);
    checkOutput("gap_next_id",  8'(gnt_id), 8'h00);
    applyStimulus(4'b0000);
    checkOutput("gap_drop", 8'(gnt), 8'h0);

    // Preemption on dut4 with MAX_HOLD of 4 and req 1001 held. The grant
    // lasts four cycles, then a preempt cycle, then a new tenure.
    doReset();
    for (int c = 1; c <= 4; c++) begin
      applyStimulus(4'b1001);
      checkOutput($sformatf("pre_gnt_c%0d", c), 8'(gnt4),     8'h08);
      checkOutput($sformatf("pre_pp_c%0d", c),  8'(preempt4), 8'h0);
    end
    applyStimulus(4'b1001);
    checkOutput("pre_release_gnt", 8'(gnt4),       8'h0);
    checkOutput("pre_release_val", 8'(gnt_valid4), 8'h0);
    checkOutput("pre_pulse",       8'(preempt4),   8'h01);
    // dut's MAX_HOLD of 8 has not been reached yet, so it keeps the grant.
    checkOutput("pre_dut8_gnt", 8'(gnt),     8'h08);
    checkOutput("pre_dut8_pp",  8'(preempt), 8'h0);
    applyStimulus(4'b1001);
`ifdef ARB_ROUND_ROBIN_EN
    checkOutput("pre_regrant",    8'(gnt4),    8'h01);
    checkOutput("pre_regrant_id", 8'(gnt_id4), 8'h00);
`else
    checkOutput("pre_regrant",    8'(gnt4),    8'h08);
    checkOutput("pre_regrant_id", 8'(gnt_id4), 8'h03);
`endif
    checkOutput("pre_pulse_end", 8'(preempt4), 8'h0);

    // Uncontended hold: req 0010 for 20 cycles is never preempted.
    doReset();
    for (int c = 0; c < 20; c++) begin
      applyStimulus(4'b0010);
      checkOutput($sformatf("unc_gnt_c%0d", c), 8'(gnt),      8'h02);
      checkOutput($sformatf("unc_pp_c%0d", c),  8'(preempt),  8'h0);
      checkOutput($sformatf("unc_pp4_c%0d", c), 8'(preempt4), 8'h0);
    end

    // Each owner in turn drops its request and reasserts it two cycles later.
    // The expected owner order depends on the arbitration mode.
    doReset();
    req = 4'b1111;
    applyStimulus(4'b1111);
    for (int k = 0; k < 5; k++) begin
      logic [3:0] r;
      logic [1:0] owner;
      checkOutput($sformatf("rr_id_%0d", k), 8'(gnt_id), 8'(rrExpect[k]));
      owner = gnt_id;
      r = 4'b1111;
      r[owner] = 1'b0;
      applyStimulus(r);
      checkOutput($sformatf("rr_gap_%0d", k), 8'(gnt_valid), 8'h0);
      applyStimulus(r);
      req = 4'b1111;
    end

    // Asynchronous reset: asserting it between edges drops the grant at once.
    // After release, arbitration restarts from IDLE on the first edge.
    doReset();
    applyStimulus(4'b0100);
    checkOutput("ar_pre_gnt", 8'(gnt), 8'h04);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_gnt",   8'(gnt),       8'h0);
    checkOutput("ar_valid", 8'(gnt_valid), 8'h0);
    checkOutput("ar_id",    8'(gnt_id),    8'h0);
    req = 4'b0010;
    #1;
    rst_n = 1'b1;
    applyStimulus(4'b0010);
    checkOutput("ar_after_gnt", 8'(gnt),    8'h02);
    checkOutput("ar_after_id",  8'(gnt_id), 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
